pb_preload_burst_packer: RTL and testbench

PB_PRELOAD_BURST_PACKER -- requirements
Module: pb_preload_burst_packer

---
 rtl/pb_preload_burst_packer.sv | 208 ++++++++++++++++++++
 tb/tb_pb_preload_burst_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_preload_burst_packer.sv
// pb_preload_burst_packer: packs a byte stream for one memory section into
// AXI write bursts. Bursts never cross a 4 KiB page and never exceed
// MaxBurstBytes. Only one burst is outstanding at a time.
// Optional feature: define PB_PACKER_BRESP_CHECK_EN to count error responses
// on the B channel in err_cnt_o (saturating). Without it err_cnt_o is zero.
module pb_preload_burst_packer #(
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 64,
    parameter int MaxBurstBytes = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [31:0]            cmd_len_i,
    input  logic                   byte_valid_i,
    output logic                   byte_ready_o,
    input  logic [7:0]             byte_i,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [7:0]             aw_len_o,
    output logic [2:0]             aw_size_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            err_cnt_o
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int LaneW     = $clog2(StrbWidth);
    localparam logic [12:0] MAX_BYTES  = 13'(MaxBurstBytes);
    localparam logic [12:0] PAGE_BYTES = 13'd4096;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_t;

    state_t                 r_state;
    logic                   r_cmd_ready;
    logic [AddrWidth-1:0]   r_addr_cur;
    logic [31:0]            r_remaining;
    logic [12:0]            r_bytes;
    logic [12:0]            r_beats;
    logic [12:0]            r_beat_cnt;
    logic [12:0]            r_burst_left;
    logic [LaneW-1:0]       r_lane;
    logic                   r_aw_valid;
    logic [AddrWidth-1:0]   r_aw_addr;
    logic [7:0]             r_aw_len;
    logic                   r_w_valid;
    logic [DataWidth-1:0]   r_data;
    logic [StrbWidth-1:0]   r_strb;
    logic                   r_w_last;
    logic                   r_b_ready;
    logic                   r_done;

    logic [12:0] w_offs, w_room_burst, w_room_page, w_room_rem, w_bytes, w_beats;
    logic        w_byte_fire, w_w_fire, w_beat_full;

    // Burst sizing for the current address: smallest of burst limit, data left and page room.
    always_comb begin
        w_offs       = 13'(r_addr_cur[LaneW-1:0]);
        w_room_burst = MAX_BYTES - w_offs;
        w_room_page  = PAGE_BYTES - {1'b0, r_addr_cur[11:0]};
        w_room_rem   = (r_remaining > 32'd4096) ? PAGE_BYTES : r_remaining[12:0];
        w_bytes      = w_room_burst;
        if (w_room_page < w_bytes) w_bytes = w_room_page;
        if (w_room_rem < w_bytes)  w_bytes = w_room_rem;
        w_beats      = (w_offs + w_bytes + 13'(StrbWidth - 1)) >> LaneW;
    end

    assign byte_ready_o = (r_state == S_W) && !r_w_valid && (r_burst_left != 13'd0);
    assign w_byte_fire  = byte_valid_i && byte_ready_o;
    assign w_w_fire     = r_w_valid && w_ready_i;
    // A beat is complete when its top lane fills or the burst runs out of bytes.
    assign w_beat_full  = (r_lane == LaneW'(StrbWidth - 1)) || (r_burst_left == 13'd1);

    // Main sequencer: command intake, burst sizing, AW issue, beat packing, response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_addr_cur   <= '0;
            r_remaining  <= '0;
            r_bytes      <= '0;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_burst_left <= '0;
            r_lane       <= '0;
            r_aw_valid   <= 1'b0;
            r_aw_addr    <= '0;
            r_aw_len     <= '0;
            r_w_valid    <= 1'b0;
            r_data       <= '0;
            r_strb       <= '0;
            r_w_last     <= 1'b0;
            r_b_ready    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid_i && r_cmd_ready) begin
                        if (cmd_len_i == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cmd_ready <= 1'b0;
                            r_addr_cur  <= cmd_addr_i;
                            r_remaining <= cmd_len_i;
                            r_state     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_bytes      <= w_bytes;
                    r_beats      <= w_beats;
                    r_burst_left <= w_bytes;
                    r_beat_cnt   <= '0;
                    r_lane       <= r_addr_cur[LaneW-1:0];
                    r_aw_valid   <= 1'b1;
                    r_aw_addr    <= {r_addr_cur[AddrWidth-1:LaneW], {LaneW{1'b0}}};
                    r_aw_len     <= 8'(w_beats - 13'd1);
                    r_state      <= S_AW;
                end
                S_AW: begin
                    if (aw_ready_i) begin
                        r_aw_valid <= 1'b0;
                        r_state    <= S_W;
                    end
                end
                S_W: begin
                    if (w_byte_fire) begin
                        r_data[{r_lane, 3'b000} +: 8] <= byte_i;
                        r_strb[r_lane]                <= 1'b1;
                        r_lane                        <= r_lane + 1'b1;
                        r_burst_left                  <= r_burst_left - 13'd1;
                        if (w_beat_full) begin
                            r_w_valid <= 1'b1;
                            r_w_last  <= (r_beat_cnt == r_beats - 13'd1);
                        end
                    end else if (w_w_fire) begin
                        r_w_valid  <= 1'b0;
                        r_data     <= '0;
                        r_strb     <= '0;
                        r_w_last   <= 1'b0;
                        r_beat_cnt <= r_beat_cnt + 13'd1;
                        if (r_w_last) begin
                            r_b_ready <= 1'b1;
                            r_state   <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (b_valid_i) begin
                        r_b_ready   <= 1'b0;
                        r_remaining <= r_remaining - 32'(r_bytes);
                        if (r_remaining == 32'(r_bytes)) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_addr_cur <= r_addr_cur + AddrWidth'(r_bytes);
                            r_state    <= S_CALC;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PB_PACKER_BRESP_CHECK_EN
    logic [15:0] r_err_cnt;

    // Count non-OKAY write responses, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (r_b_ready && b_valid_i && (b_resp_i != 2'b00) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^b_resp_i;
    assign err_cnt_o     = '0;
`endif

    assign cmd_ready_o = r_cmd_ready;
    assign aw_valid_o  = r_aw_valid;
    assign aw_addr_o   = r_aw_addr;
    assign aw_len_o    = r_aw_len;
    assign aw_size_o   = 3'(LaneW);
    assign w_valid_o   = r_w_valid;
    assign w_data_o    = r_data;
    assign w_strb_o    = r_strb;
    assign w_last_o    = r_w_last;
    assign b_ready_o   = r_b_ready;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
endmodule

// File: tb/tb_pb_preload_burst_packer.sv
// Testbench for pb_preload_burst_packer: directed corner cases plus random
// commands, checked against a byte-level model of the burst splitting rules.
module tb_pb_preload_burst_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [47:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        byte_valid, byte_ready;
    logic [7:0]  byte_in;
    logic        aw_valid, aw_ready;
    logic [47:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        busy, done;
    logic [15:0] err_cnt;

`ifdef PB_PACKER_BRESP_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    always #5 clk = ~clk;

    pb_preload_burst_packer #(.AddrWidth(48), .DataWidth(64), .MaxBurstBytes(1024)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .byte_valid_i(byte_valid), .byte_ready_o(byte_ready), .byte_i(byte_in),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
        .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected traffic, produced by the model
    logic [47:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic [63:0] exp_w_data[$];
    logic [7:0]  exp_w_strb[$];
    logic        exp_w_last[$];
    logic [7:0]  cmd_bytes[$];
    logic [1:0]  resp_q[$];
    bit          stall_en = 1'b0;
    int          aw_seen = 0;
    int          aw_valid_cycles = 0;
    int          w_valid_cycles = 0;

    // Model: walk the section, split into bursts, then place each byte in its beat and lane.
    task automatic model_cmd(input longint unsigned a, input int len);
        longint unsigned cur;
        int rem, idx, offs, pg, nb, beats;
        logic [63:0] d;
        logic [7:0]  s;
        cur = a; rem = len; idx = 0;
        while (rem > 0) begin
            offs = int'(cur % 8);
            pg   = 4096 - int'(cur % 4096);
            nb   = 1024 - offs;
            if (rem < nb) nb = rem;
            if (pg < nb)  nb = pg;
            beats = (offs + nb + 7) / 8;
            exp_aw_addr.push_back(48'(cur - longint'(offs)));
            exp_aw_len.push_back(8'(beats - 1));
            for (int k = 0; k < beats; k++) begin
                d = '0; s = '0;
                for (int i = 0; i < nb; i++) begin
                    if ((offs + i) / 8 == k) begin
                        d[((offs + i) % 8) * 8 +: 8] = cmd_bytes[idx + i];
                        s[(offs + i) % 8] = 1'b1;
                    end
                end
                exp_w_data.push_back(d);
                exp_w_strb.push_back(s);
                exp_w_last.push_back(k == beats - 1);
            end
            cur += longint'(nb); rem -= nb; idx += nb;
        end
    endtask

    // Monitor: compare every AW and W handshake against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_valid) aw_valid_cycles++;
            if (w_valid)  w_valid_cycles++;
            if (aw_valid && aw_ready) begin
                aw_seen++;
                if (exp_aw_addr.size() == 0) begin
                    chk("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("aw_addr", 64'(aw_addr), 64'(exp_aw_addr.pop_front()));
                    chk("aw_len",  64'(aw_len),  64'(exp_aw_len.pop_front()));
                    chk("aw_size", 64'(aw_size), 64'd3);
                end
            end
            if (w_valid && w_ready) begin
                if (exp_w_data.size() == 0) begin
                    chk("w_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("w_data", w_data, exp_w_data.pop_front());
                    chk("w_strb", 64'(w_strb), 64'(exp_w_strb.pop_front()));
                    chk("w_last", 64'(w_last), 64'(exp_w_last.pop_front()));
                end
            end
        end
    end

    // Ready generators for AW and W, optionally stalling at random.
    initial begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        forever begin
            @(posedge clk); #1;
            aw_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            w_ready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // B responder: answer each completed burst after a short random delay.
    initial begin
        bit got;
        b_valid = 1'b0;
        b_resp  = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n && w_valid && w_ready && w_last) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                b_valid = 1'b1;
                b_resp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                got = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (b_ready) begin got = 1'b1; break; end
                end
                if (!got && rst_n) chk("b_ready_timeout", 64'd0, 64'd1);
                @(posedge clk); #1;
                b_valid = 1'b0;
                b_resp  = 2'b00;
            end
        end
    end

    task automatic send_cmd(input logic [47:0] a, input int len);
        bit ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 32'(len);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("cmd_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Feed bytes [first, first+n) of cmd_bytes; returns 0 on a stuck stream.
    task automatic send_bytes(input int first, input int n, output bit ok);
        ok = 1'b1;
        for (int i = first; i < first + n; i++) begin
            bit taken = 1'b0;
            byte_valid = 1'b1;
            byte_in    = cmd_bytes[i];
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (byte_ready) begin taken = 1'b1; break; end
            end
            if (!taken) begin
                chk("byte_timeout", 64'd0, 64'd1);
                byte_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [47:0] a, input int len, input int exp_aws);
        int aw0, awv0;
        bit ok, seen;
        cmd_bytes.delete();
        for (int i = 0; i < len; i++) cmd_bytes.push_back(8'($urandom));
        model_cmd(longint'(a), len);
        aw0  = aw_seen;
        awv0 = aw_valid_cycles;
        send_cmd(a, len);
        if (len == 0) begin
            @(negedge clk);
            chk("len0_done", 64'(done), 64'd1);
            @(negedge clk);
            chk("len0_done_pulse", 64'(done), 64'd0);
            repeat (5) @(negedge clk);
            chk("len0_no_aw", 64'(aw_valid_cycles - awv0), 64'd0);
            return;
        end
        send_bytes(0, len, ok);
        if (!ok) return;
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk("done", 64'(seen), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("aw_left", 64'(exp_aw_addr.size()), 64'd0);
        chk("w_left", 64'(exp_w_data.size()), 64'd0);
        if (exp_aws >= 0) chk("aw_count", 64'(aw_seen - aw0), 64'(exp_aws));
        $display("cmd addr=%h len=%0d bursts=%0d", a, len, aw_seen - aw0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_aw_valid"}, 64'(aw_valid), 64'd0);
        chk({pfx, "_w_valid"}, 64'(w_valid), 64'd0);
        chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({pfx, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({pfx, "_b_ready"}, 64'(b_ready), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_w_data"}, w_data, 64'd0);
        chk({pfx, "_w_strb"}, 64'(w_strb), 64'd0);
        chk({pfx, "_w_last"}, 64'(w_last), 64'd0);
        chk({pfx, "_aw_addr"}, 64'(aw_addr), 64'd0);
        chk({pfx, "_aw_len"}, 64'(aw_len), 64'd0);
        chk({pfx, "_err_cnt"}, 64'(err_cnt), 64'd0);
    endtask

    initial begin
        bit ok;
        int awv0, wv0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        byte_valid = 1'b0; byte_in = '0;
        #22;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Aligned two-beat burst, full strobes
        run_cmd(48'h7000_0000, 16, 1);
        // Unaligned start inside one beat pair
        run_cmd(48'h7000_0003, 6, 1);
        // Page crossing splits in two; first response is an error
        resp_q.push_back(2'b10);
        resp_q.push_back(2'b00);
        run_cmd(48'h7000_0FF8, 16, 2);
        chk("err_cnt", 64'(err_cnt), 64'(EXP_ERR));
        // Two maximum bursts under random back-pressure
        stall_en = 1'b1;
        run_cmd(48'h7000_0000, 2048, 2);
        // Random sections
        for (int n = 0; n < 14; n++) begin
            logic [47:0] a;
            int len;
            a   = 48'h7000_0000 + 48'($urandom_range(0, 16383));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, 2100)) : int'($urandom_range(1, 200));
            stall_en = ($urandom_range(0, 1) == 1);
            run_cmd(a, len, -1);
        end
        // Zero-length section
        stall_en = 1'b0;
        run_cmd(48'h7000_0100, 0, 0);

        // Reset in the middle of a burst's data phase
        cmd_bytes.delete();
        for (int i = 0; i < 64; i++) cmd_bytes.push_back(8'($urandom));
        model_cmd(64'h7000_0000, 64);
        send_cmd(48'h7000_0000, 64);
        send_bytes(0, 13, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        exp_aw_addr.delete(); exp_aw_len.delete();
        exp_w_data.delete(); exp_w_strb.delete(); exp_w_last.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        awv0 = aw_valid_cycles;
        wv0  = w_valid_cycles;
        repeat (50) @(negedge clk);
        chk("abort_no_aw", 64'(aw_valid_cycles - awv0), 64'd0);
        chk("abort_no_w", 64'(w_valid_cycles - wv0), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        $display("abort reset checked");

        // Normal operation resumes after the abort
        run_cmd(48'h7000_0010, 40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
